// File: rtl/adc_ltc2311_pkg.sv
// rtl/adc_ltc2311_pkg.sv - shared types and constants for the LTC2311 capture engine
// Contents: capture FSM state type, parameter defaults, sample-delay limit,
// timestamp width and a counter-width helper.
package adc_ltc2311_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CONV  = 2'd1,
        SHIFT = 2'd2,
        DRAIN = 2'd3
    } state_t;

    localparam int DEF_CHANNELS     = 8;
    localparam int DEF_DATA_WIDTH   = 16;
    localparam int DEF_CLK_DIV      = 2;
    localparam int DEF_CNV_CYCLES   = 3;
    localparam int DEF_CONV_CYCLES  = 14;
    localparam int DEF_SAMPLE_DELAY = 0;

    localparam int SAMPLE_DELAY_MAX = 7;
    localparam int TS_WIDTH         = 32;

    // Width of a counter that must hold values 0..n.
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/adc_ltc2311_if.sv
// rtl/adc_ltc2311_if.sv - serial bus shared by a bank of LTC2311 ADCs
// Signals: cnv_o  conversion start to all ADCs
//          sck_o  shared serial clock
//          sdo_i  one serial data line per ADC
// Modports: master = capture engine, slave = ADC bank / model.
interface adc_ltc2311_if
    import adc_ltc2311_pkg::*;
#(
    parameter int CHANNELS = DEF_CHANNELS
);
    logic                cnv_o;
    logic                sck_o;
    logic [CHANNELS-1:0] sdo_i;

    modport master (
        output cnv_o,
        output sck_o,
        input  sdo_i
    );

    modport slave (
        input  cnv_o,
        input  sck_o,
        output sdo_i
    );
endinterface

// File: rtl/adc_ltc2311_sck_gen.sv
// rtl/adc_ltc2311_sck_gen.sv - serial clock divider for the LTC2311 capture engine
// Ports: clk, resetn      clock and synchronous active-low reset
//        start            load pulse; sck goes high on the following cycle
//        sck              registered serial clock, DATA_WIDTH pulses per frame
//        fall             high in the last high cycle of a pulse (sck falls on the next edge)
//        last             current pulse is the final bit
//        done             high in the last low cycle of the final pulse
module adc_ltc2311_sck_gen
    import adc_ltc2311_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int CLK_DIV    = DEF_CLK_DIV
) (
    input  logic clk,
    input  logic resetn,
    input  logic start,
    output logic sck,
    output logic fall,
    output logic last,
    output logic done
);
    localparam int DW = cnt_width(CLK_DIV);
    localparam int BW = cnt_width(DATA_WIDTH);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);

    logic          active;
    logic [DW-1:0] div_cnt;
    logic [BW-1:0] bit_cnt;
    logic          phase_end;

    assign phase_end = active && (div_cnt == DIV_LAST);
    assign last      = (bit_cnt == BIT_LAST);
    assign fall      = phase_end && sck;
    assign done      = phase_end && !sck && last;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            active  <= 1'b0;
            sck     <= 1'b0;
            div_cnt <= '0;
            bit_cnt <= '0;
        end else if (start) begin
            active  <= 1'b1;
            sck     <= 1'b1;
            div_cnt <= '0;
            bit_cnt <= '0;
        end else if (phase_end) begin
            div_cnt <= '0;
            if (sck) begin
                sck <= 1'b0;
            end else if (last) begin
                active <= 1'b0;
            end else begin
                bit_cnt <= bit_cnt + 1'b1;
                sck     <= 1'b1;
            end
        end else if (active) begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/adc_ltc2311_capture.sv
// rtl/adc_ltc2311_capture.sv - acquisition engine for a bank of LTC2311 ADCs sharing CNV/SCK
// Ports: ACLK, ARESETN   clock and synchronous active-low reset
//        trigger_i       single-shot start (level, sampled in IDLE)
//        continuous_i    restart automatically after each result
//        chan_en_i       per-channel enable, latched at conversion start
//        overrun_clr_i   clears overrun_o (a simultaneous new overrun wins)
//        adc             serial bus master (cnv_o, sck_o, sdo_i)
//        data_o          results, channel n at [n*DATA_WIDTH +: DATA_WIDTH]
//        valid_o         one-cycle pulse when data_o updates
//        busy_o          high outside IDLE
//        overrun_o       sticky, trigger seen while busy
//        ts_o            conversion timestamp (only with ADC_LTC2311_TIMESTAMP_EN)
// Optional feature macro: ADC_LTC2311_TIMESTAMP_EN
module adc_ltc2311_capture
    import adc_ltc2311_pkg::*;
#(
    parameter int CHANNELS     = DEF_CHANNELS,
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int CLK_DIV      = DEF_CLK_DIV,
    parameter int CNV_CYCLES   = DEF_CNV_CYCLES,
    parameter int CONV_CYCLES  = DEF_CONV_CYCLES,
    parameter int SAMPLE_DELAY = DEF_SAMPLE_DELAY
) (
    input  logic                           ACLK,
    input  logic                           ARESETN,
    input  logic                           trigger_i,
    input  logic                           continuous_i,
    input  logic [CHANNELS-1:0]            chan_en_i,
    input  logic                           overrun_clr_i,
    adc_ltc2311_if.master                  adc,
    output logic [CHANNELS*DATA_WIDTH-1:0] data_o,
    output logic                           valid_o,
    output logic                           busy_o,
    output logic                           overrun_o
`ifdef ADC_LTC2311_TIMESTAMP_EN
    ,
    output logic [TS_WIDTH-1:0]            ts_o
`endif
);
    // Out-of-range delays saturate rather than build a longer line.
    localparam int SD = (SAMPLE_DELAY > SAMPLE_DELAY_MAX) ? SAMPLE_DELAY_MAX : SAMPLE_DELAY;
    localparam int CW = cnt_width(CONV_CYCLES);
    localparam logic [CW-1:0] CNV_LAST  = CW'(CNV_CYCLES - 1);
    localparam logic [CW-1:0] CONV_LAST = CW'(CONV_CYCLES - 1);

    state_t                           state;
    state_t                           state_nxt;
    logic                             start_conv;
    logic                             start_shift;
    logic [CW-1:0]                    conv_cnt;
    logic                             cnv_q;
    logic [CHANNELS-1:0]              chan_en_q;
    logic [CHANNELS*DATA_WIDTH-1:0]   sh_q;
    logic [CHANNELS*DATA_WIDTH-1:0]   sh_nxt;

    logic sck_q;
    logic sck_fall;
    logic sck_last;
    logic sck_done;

    // Capture strobe after the round-trip delay line.
    logic cap_en;
    logic cap_last;
    logic pending;

    assign adc.cnv_o = cnv_q;
    assign adc.sck_o = sck_q;
    assign busy_o    = (state != IDLE);

    adc_ltc2311_sck_gen #(
        .DATA_WIDTH (DATA_WIDTH),
        .CLK_DIV    (CLK_DIV)
    ) u_sck_gen (
        .clk    (ACLK),
        .resetn (ARESETN),
        .start  (start_shift),
        .sck    (sck_q),
        .fall   (sck_fall),
        .last   (sck_last),
        .done   (sck_done)
    );

    // The fall strobe and its last-bit tag travel together so the final
    // capture (and valid_o) land exactly SD cycles after the last SCK fall.
    generate
        if (SD == 0) begin : g_no_delay
            assign cap_en   = sck_fall;
            assign cap_last = sck_fall && sck_last;
            assign pending  = 1'b0;
        end else begin : g_delay
            logic [SD-1:0] dl_en;
            logic [SD-1:0] dl_last;
            logic [SD:0]   en_shift;
            logic [SD:0]   last_shift;

            assign en_shift   = {dl_en, sck_fall};
            assign last_shift = {dl_last, sck_fall && sck_last};
            assign cap_en     = dl_en[SD-1];
            assign cap_last   = dl_last[SD-1];
            assign pending    = |dl_en;

            always_ff @(posedge ACLK) begin
                if (!ARESETN) begin
                    dl_en   <= '0;
                    dl_last <= '0;
                end else begin
                    dl_en   <= en_shift[SD-1:0];
                    dl_last <= last_shift[SD-1:0];
                end
            end
        end
    endgenerate

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Leaving SHIFT with nothing still in the delay line lets a continuous
    // restart begin right after the last SCK low phase.
    always_comb begin
        state_nxt   = state;
        start_conv  = 1'b0;
        start_shift = 1'b0;
        case (state)
            IDLE: begin
                if (trigger_i || continuous_i) begin
                    state_nxt  = CONV;
                    start_conv = 1'b1;
                end
            end
            CONV: begin
                if (conv_cnt == CONV_LAST) begin
                    state_nxt   = SHIFT;
                    start_shift = 1'b1;
                end
            end
            SHIFT: begin
                if (sck_done) begin
                    if (pending) begin
                        state_nxt = DRAIN;
                    end else if (continuous_i) begin
                        state_nxt  = CONV;
                        start_conv = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            DRAIN: begin
                if (!pending) begin
                    if (continuous_i) begin
                        state_nxt  = CONV;
                        start_conv = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Disabled channels shift in zeros, so after a full frame they read 0.
    always_comb begin
        sh_nxt = '0;
        for (int n = 0; n < CHANNELS; n++) begin
            sh_nxt[n*DATA_WIDTH +: DATA_WIDTH] =
                {sh_q[n*DATA_WIDTH +: DATA_WIDTH-1], adc.sdo_i[n] & chan_en_q[n]};
        end
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            conv_cnt  <= '0;
            cnv_q     <= 1'b0;
            chan_en_q <= '0;
            sh_q      <= '0;
            data_o    <= '0;
            valid_o   <= 1'b0;
            overrun_o <= 1'b0;
        end else begin
            valid_o <= cap_en && cap_last;
            if (cap_en) begin
                sh_q <= sh_nxt;
            end
            if (cap_en && cap_last) begin
                data_o <= sh_nxt;
            end

            if (start_conv) begin
                cnv_q     <= 1'b1;
                conv_cnt  <= '0;
                chan_en_q <= chan_en_i;
            end else if (state == CONV) begin
                conv_cnt <= conv_cnt + 1'b1;
                cnv_q    <= (conv_cnt < CNV_LAST);
            end

            if (trigger_i && busy_o) begin
                overrun_o <= 1'b1;
            end else if (overrun_clr_i) begin
                overrun_o <= 1'b0;
            end
        end
    end

`ifdef ADC_LTC2311_TIMESTAMP_EN
    logic [TS_WIDTH-1:0] ts_cnt;
    logic [TS_WIDTH-1:0] ts_cap;

    // ts_cap holds the counter value of the first cnv_o-high cycle, which is
    // ts_cnt+1 at the edge that raises cnv_o.
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            ts_cnt <= '0;
            ts_cap <= '0;
            ts_o   <= '0;
        end else begin
            ts_cnt <= ts_cnt + 1'b1;
            if (start_conv) begin
                ts_cap <= ts_cnt + 1'b1;
            end
            if (cap_en && cap_last) begin
                ts_o <= ts_cap;
            end
        end
    end
`endif

endmodule

// File: tb/tb_adc_ltc2311_capture.sv
// tb/tb_adc_ltc2311_capture.sv - self-checking bench for adc_ltc2311_capture
module tb_adc_ltc2311_capture;
    import adc_ltc2311_pkg::*;

    localparam int CH   = DEF_CHANNELS;
    localparam int W    = DEF_DATA_WIDTH;
    localparam int DIV  = DEF_CLK_DIV;
    localparam int CNV  = DEF_CNV_CYCLES;
    localparam int CONV = DEF_CONV_CYCLES;

    logic ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    logic          resetn0, trig0, cont0, clr0;
    logic          resetn3, trig3, cont3, clr3;
    logic [CH-1:0] en0, en3;
    logic [CH*W-1:0] data0, data3;
    logic          valid0, busy0, ovr0;
    logic          valid3, busy3, ovr3;
`ifdef ADC_LTC2311_TIMESTAMP_EN
    logic [31:0]   ts0, ts3;
    logic [31:0]   ts_m;
`endif

    adc_ltc2311_if #(.CHANNELS(CH)) bus0 ();
    adc_ltc2311_if #(.CHANNELS(CH)) bus3 ();

    adc_ltc2311_capture u_dut0 (
        .ACLK          (ACLK),
        .ARESETN       (resetn0),
        .trigger_i     (trig0),
        .continuous_i  (cont0),
        .chan_en_i     (en0),
        .overrun_clr_i (clr0),
        .adc           (bus0),
        .data_o        (data0),
        .valid_o       (valid0),
        .busy_o        (busy0),
        .overrun_o     (ovr0)
`ifdef ADC_LTC2311_TIMESTAMP_EN
        ,
        .ts_o          (ts0)
`endif
    );

    adc_ltc2311_capture #(.SAMPLE_DELAY(3)) u_dut3 (
        .ACLK          (ACLK),
        .ARESETN       (resetn3),
        .trigger_i     (trig3),
        .continuous_i  (cont3),
        .chan_en_i     (en3),
        .overrun_clr_i (clr3),
        .adc           (bus3),
        .data_o        (data3),
        .valid_o       (valid3),
        .busy_o        (busy3),
        .overrun_o     (ovr3)
`ifdef ADC_LTC2311_TIMESTAMP_EN
        ,
        .ts_o          (ts3)
`endif
    );

    int vectors    = 0;
    int miscompares = 0;
    int cyc        = 0;

    // ---------------- reference model ----------------
    logic [CH*W-1:0] words0, words3;
    int   fc0 = W, fc3 = W;
    logic psck0 = 1'b0, psck3 = 1'b0;
    logic [CH-1:0] s0, s3, hist3 [3];

`ifdef ADC_LTC2311_TIMESTAMP_EN
    always @(posedge ACLK) ts_m <= !resetn0 ? 32'd0 : ts_m + 32'd1;
`endif

    // Each ADC presents bit k until the k-th SCK fall; dut3's lines arrive 3 cycles late.
    always begin
        @(posedge ACLK);
        #2;
        if (bus0.cnv_o) fc0 = 0;
        else if (psck0 && !bus0.sck_o) fc0++;
        psck0 = bus0.sck_o;
        for (int n = 0; n < CH; n++) s0[n] = (fc0 < W) ? words0[n*W + (W-1-fc0)] : 1'b0;
        bus0.sdo_i = s0;

        if (bus3.cnv_o) fc3 = 0;
        else if (psck3 && !bus3.sck_o) fc3++;
        psck3 = bus3.sck_o;
        for (int n = 0; n < CH; n++) s3[n] = (fc3 < W) ? words3[n*W + (W-1-fc3)] : 1'b0;
        bus3.sdo_i = hist3[2];
        hist3[2] = hist3[1];
        hist3[1] = hist3[0];
        hist3[0] = s3;
    end

    function automatic logic [CH*W-1:0] ref_data(input logic [CH*W-1:0] words, input logic [CH-1:0] en);
        logic [CH*W-1:0] r;
        r = '0;
        for (int n = 0; n < CH; n++) r[n*W +: W] = en[n] ? words[n*W +: W] : '0;
        return r;
    endfunction

    function automatic int ref_valid_ofs(input int sd);
        return 1 + CONV + (2*W - 1)*DIV + sd;
    endfunction

    function automatic int ref_period();
        int a, b;
        a = ref_valid_ofs(0);
        b = CONV + 2*W*DIV;
        return (a > b) ? a : b;
    endfunction

    function automatic logic [CH*W-1:0] rand_words();
        logic [CH*W-1:0] r;
        for (int n = 0; n < CH; n++) r[n*W +: W] = W'($urandom) | W'(1);
        return r;
    endfunction

    // ---------------- checking helpers ----------------
    task automatic chk_vec(input string tag, input logic [CH*W-1:0] obs, input logic [CH*W-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
        cyc++;
    endtask

    // One single-shot frame on dut0 (sel=0) or dut3 (sel=1), all timing checked.
    task automatic frame(input int sel, input logic [CH-1:0] en, input string tag);
        int t0, cnv_first, cnv_last, sck_first, vcyc, vcnt, sd;
        logic c, s, v, b, o;
        logic [CH*W-1:0] d, vdata, words;
`ifdef ADC_LTC2311_TIMESTAMP_EN
        logic [31:0] ts_exp, ts_got;
        ts_exp = '0;
        ts_got = '1;
`endif
        cnv_first = -1; cnv_last = -1; sck_first = -1; vcyc = -1; vcnt = 0;
        vdata = 'x;
        sd = (sel == 0) ? 0 : 3;
        if (sel == 0) begin en0 = en; trig0 = 1'b1; words = words0; end
        else          begin en3 = en; trig3 = 1'b1; words = words3; end
        t0 = cyc;
        tick();
        trig0 = 1'b0;
        trig3 = 1'b0;
        b = 1'b1;
        o = 1'b0;
        for (int i = 0; i < 150; i++) begin
            c = (sel == 0) ? bus0.cnv_o : bus3.cnv_o;
            s = (sel == 0) ? bus0.sck_o : bus3.sck_o;
            v = (sel == 0) ? valid0 : valid3;
            b = (sel == 0) ? busy0 : busy3;
            o = (sel == 0) ? ovr0 : ovr3;
            d = (sel == 0) ? data0 : data3;
            if (c) begin
`ifdef ADC_LTC2311_TIMESTAMP_EN
                if (cnv_first < 0) ts_exp = ts_m;
`endif
                if (cnv_first < 0) cnv_first = cyc;
                cnv_last = cyc;
            end
            if (s && sck_first < 0) sck_first = cyc;
            if (v) begin
                vcnt++;
                vcyc = cyc;
                vdata = d;
`ifdef ADC_LTC2311_TIMESTAMP_EN
                ts_got = ts0;
`endif
            end
            if (vcnt > 0 && !b) break;
            tick();
        end
        chk_int({tag, "/cnv_first"}, cnv_first, t0 + 1);
        chk_int({tag, "/cnv_last"}, cnv_last, t0 + CNV);
        chk_int({tag, "/sck_first"}, sck_first, t0 + 1 + CONV);
        chk_int({tag, "/valid_cycle"}, vcyc, t0 + ref_valid_ofs(sd));
        chk_int({tag, "/valid_count"}, vcnt, 1);
        chk_vec({tag, "/data"}, vdata, ref_data(words, en));
        chk_bit({tag, "/busy_end"}, b, 1'b0);
        chk_bit({tag, "/overrun"}, o, 1'b0);
`ifdef ADC_LTC2311_TIMESTAMP_EN
        if (sel == 0) chk_vec({tag, "/ts"}, {{(CH*W-32){1'b0}}, ts_got}, {{(CH*W-32){1'b0}}, ts_exp});
`endif
        tick();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t0, nv, vtimes [3];
        resetn0 = 1'b0; trig0 = 1'b0; cont0 = 1'b0; clr0 = 1'b0; en0 = '0;
        resetn3 = 1'b0; trig3 = 1'b0; cont3 = 1'b0; clr3 = 1'b0; en3 = '0;
        for (int n = 0; n < CH; n++) words0[n*W +: W] = 16'hA500 + W'(n);
        words3 = rand_words();
        for (int k = 0; k < 3; k++) hist3[k] = '0;
        repeat (3) tick();
        resetn0 = 1'b1;
        resetn3 = 1'b1;
        tick();

        // reset state
        chk_bit("rst/cnv", bus0.cnv_o, 1'b0);
        chk_bit("rst/sck", bus0.sck_o, 1'b0);
        chk_bit("rst/valid", valid0, 1'b0);
        chk_bit("rst/busy", busy0, 1'b0);
        chk_bit("rst/overrun", ovr0, 1'b0);
        chk_vec("rst/data", data0, '0);
        chk_bit("rst/busy3", busy3, 1'b0);
        chk_vec("rst/data3", data3, '0);

        // single frames with several enable patterns and data words
        frame(0, '1, "s1_all");
        words0 = rand_words();
        frame(0, 8'b0000_0101, "s2_en05");
        for (int k = 0; k < 3; k++) begin
            words0 = rand_words();
            frame(0, CH'($urandom), "rnd");
        end
        words0 = rand_words();
        frame(0, '0, "all_off");
        frame(1, '1, "s3_delay3");
        words3 = rand_words();
        frame(1, 8'b1010_0011, "s3_delay3_mask");

        // continuous mode: three frames, then back to IDLE
        words0 = rand_words();
        en0 = '1;
        cont0 = 1'b1;
        t0 = cyc;
        tick();
        nv = 0;
        for (int i = 0; i < 400; i++) begin
            if (valid0) begin
                vtimes[nv] = cyc;
                chk_vec("s4/data", data0, words0);
                nv++;
                if (nv == 3) begin
                    cont0 = 1'b0;
                    break;
                end
            end
            tick();
        end
        chk_int("s4/valid_count", nv, 3);
        chk_int("s4/first_valid", vtimes[0], t0 + ref_valid_ofs(0));
        chk_int("s4/spacing1", vtimes[1] - vtimes[0], ref_period());
        chk_int("s4/spacing2", vtimes[2] - vtimes[1], ref_period());
        tick();
        chk_bit("s4/busy_tail", busy0, 1'b1);
        tick();
        chk_bit("s4/busy_idle", busy0, 1'b0);
        repeat (5) tick();
        chk_bit("s4/still_idle", busy0, 1'b0);
        chk_bit("s4/no_cnv", bus0.cnv_o, 1'b0);

        // overrun set, set-wins-over-clear, then clear
        trig0 = 1'b1;
        tick();
        trig0 = 1'b0;
        repeat (19) tick();
        trig0 = 1'b1;
        tick();
        trig0 = 1'b0;
        chk_bit("s5/overrun_set", ovr0, 1'b1);
        repeat (8) tick();
        trig0 = 1'b1;
        clr0 = 1'b1;
        tick();
        trig0 = 1'b0;
        chk_bit("s5/set_wins", ovr0, 1'b1);
        tick();
        clr0 = 1'b0;
        chk_bit("s5/cleared", ovr0, 1'b0);
        for (int i = 0; i < 120; i++) begin
            if (!busy0) break;
            tick();
        end
        chk_bit("s5/frame_end", busy0, 1'b0);
        tick();

        // reset mid-SHIFT
        words0 = rand_words();
        en0 = '1;
        trig0 = 1'b1;
        tick();
        trig0 = 1'b0;
        repeat (39) tick();
        resetn0 = 1'b0;
        tick();
        chk_bit("s6/cnv", bus0.cnv_o, 1'b0);
        chk_bit("s6/sck", bus0.sck_o, 1'b0);
        chk_bit("s6/busy", busy0, 1'b0);
        chk_bit("s6/valid", valid0, 1'b0);
        chk_vec("s6/data", data0, '0);
`ifdef ADC_LTC2311_TIMESTAMP_EN
        chk_vec("s6/ts", {{(CH*W-32){1'b0}}, ts0}, '0);
`endif
        resetn0 = 1'b1;
        nv = 0;
        for (int i = 0; i < 100; i++) begin
            if (valid0) nv++;
            tick();
        end
        chk_int("s6/no_valid", nv, 0);
        frame(0, '1, "post_reset");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
